// File: rtl/console_pkg.sv
// Shared constants for the console transmit buffer:
// register map, status layout and drain FSM states.
package console_pkg;

  localparam int CON_W = 32;

  localparam logic ADDR_TXDATA = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } con_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full
// is taken only when a pop lands on the same edge.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop_i && !empty_o;
    wr_en    = push_i && (!full_o || rd_en);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/console_tx_buffer.sv
// CPU-facing character buffer that drains into the console
// one word per stb/ack transaction.
module console_tx_buffer
  import console_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic              i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic [31:0]       o_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic              o_con_stb,
  output logic [CON_W-1:0]  o_con_data,
  input  logic              i_con_ack,
  input  logic              i_con_stall
);

  con_state_e          state_q, state_d;
  logic                ack_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                stb_q, stb_d;
  logic [CON_W-1:0]    cdata_q, cdata_d;
  logic                ovf_q, ovf_d;

  logic                wr_txd, wr_st, rd_st;
  logic                pop;
  logic                full, empty;
  logic [DATA_W-1:0]   head;
  logic [DEPTH_LOG2:0] count;
  logic [31:0]         status;
  logic                unused_hi;

  assign unused_hi = ^i_wb_data[31:DATA_W];

  sync_fifo #(
    .W  (DATA_W),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .push_i  (wr_txd),
    .data_i  (i_wb_data[DATA_W-1:0]),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    wr_txd = i_wb_stb && i_wb_we && (i_wb_addr == ADDR_TXDATA);
    wr_st  = i_wb_stb && i_wb_we && (i_wb_addr == ADDR_STATUS);
    rd_st  = i_wb_stb && !i_wb_we && (i_wb_addr == ADDR_STATUS);
    pop    = (state_q == S_IDLE) && !empty && !i_con_stall;

    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf_q;
    status[ST_COUNT_LSB +: DEPTH_LOG2+1] = count;

    rdata_d = rd_st ? status : '0;

    // a dropped push outranks a same-edge clear
    ovf_d = ovf_q;
    if (wr_st && i_wb_data[ST_OVF]) ovf_d = 1'b0;
    if (wr_txd && full && !pop)     ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    stb_d   = 1'b0;
    cdata_d = cdata_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          stb_d   = 1'b1;
          cdata_d = CON_W'(head);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_con_ack) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      stb_q   <= 1'b0;
      cdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= i_wb_stb;
      rdata_q <= rdata_d;
      stb_q   <= stb_d;
      cdata_q <= cdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;
  assign o_con_stb  = stb_q;
  assign o_con_data = cdata_q;

endmodule

// File: tb/tb_console_tx_buffer.sv
// Directed bench: CPU-side vector table plus console-side
// sequences driven by a configurable ack responder.
module tb_console_tx_buffer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_addr = 1'b0;
  logic [31:0] i_wb_data = '0;
  logic [31:0] o_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic        o_con_stb;
  logic [31:0] o_con_data;
  logic        i_con_ack = 1'b0;
  logic        i_con_stall = 1'b1;

  int errors = 0;
  int checks = 0;

  int          ack_delay = 1;
  bit          chk_stable = 1'b1;
  bit          outst = 1'b0;
  int          cnt = 0;
  logic [31:0] last_data = '0;
  logic [31:0] rx[$];

  console_tx_buffer dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_wb_stb    (i_wb_stb),
    .i_wb_we     (i_wb_we),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .o_wb_data   (o_wb_data),
    .o_wb_ack    (o_wb_ack),
    .o_wb_stall  (o_wb_stall),
    .o_con_stb   (o_con_stb),
    .o_con_data  (o_con_data),
    .i_con_ack   (i_con_ack),
    .i_con_stall (i_con_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Console model: records each stb, acks after ack_delay cycles
  always @(negedge clk) begin
    if (i_con_ack) begin
      i_con_ack = 1'b0;
      outst = 1'b0;
    end else if (outst) begin
      chk("stb_while_waiting", {31'b0, o_con_stb}, 32'h0);
      if (chk_stable) chk("con_data_stable", o_con_data, last_data);
      if (cnt == 0) i_con_ack = 1'b1;
      else cnt--;
    end
    if (o_con_stb) begin
      chk("one_outstanding", {31'b0, outst}, 32'h0);
      rx.push_back(o_con_data);
      last_data = o_con_data;
      outst = 1'b1;
      if (ack_delay == 0) i_con_ack = 1'b1;
      else cnt = ack_delay - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic addr,
                    input logic [31:0] d);
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = d;
    step();
    i_wb_stb  = 1'b0;
    i_wb_we   = 1'b0;
    i_wb_data = '0;
  endtask

  task automatic rd_status(input string nm, input logic [31:0] exp);
    wb(1'b0, 1'b1, 32'h0);
    chk({nm, "_ack"}, {31'b0, o_wb_ack}, 32'h1);
    chk(nm, o_wb_data, exp);
  endtask

  task automatic wait_rx(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(nm, rx.size(), n);
  endtask

  typedef struct {
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t tbl[9];
  logic [31:0] exp_q[$];

  initial begin
    tbl[0] = '{1, 0, 1, 32'h0,  1, 32'h0000_0002, "st_empty"};
    tbl[1] = '{1, 1, 0, 32'h41, 1, 32'h0,         "wr_A"};
    tbl[2] = '{1, 0, 1, 32'h0,  1, 32'h0000_0100, "st_cnt1"};
    tbl[3] = '{1, 1, 0, 32'h42, 1, 32'h0,         "wr_B"};
    tbl[4] = '{1, 1, 0, 32'h43, 1, 32'h0,         "wr_C"};
    tbl[5] = '{1, 0, 1, 32'h0,  1, 32'h0000_0300, "st_cnt3"};
    tbl[6] = '{1, 0, 0, 32'h0,  1, 32'h0,         "rd_txdata"};
    tbl[7] = '{0, 0, 0, 32'h0,  0, 32'h0,         "idle"};
    tbl[8] = '{1, 0, 1, 32'h0,  1, 32'h0000_0300, "st_cnt3b"};

    // reset state
    i_reset = 1'b1;
    step();
    step();
    chk("rst_wb_ack", {31'b0, o_wb_ack}, 32'h0);
    chk("rst_wb_data", o_wb_data, 32'h0);
    chk("rst_con_stb", {31'b0, o_con_stb}, 32'h0);
    chk("rst_con_data", o_con_data, 32'h0);
    chk("wb_stall", {31'b0, o_wb_stall}, 32'h0);
    i_reset = 1'b0;

    // single character, ack one cycle after stb
    i_con_stall = 1'b0;
    ack_delay = 1;
    wb(1'b1, 1'b0, 32'hFFFF_FF41);
    chk("wr41_ack", {31'b0, o_wb_ack}, 32'h1);
    wait_rx("rx41_cnt", 1, 20);
    if (rx.size() >= 1) chk("rx41_data", rx[0], 32'h41);
    repeat (4) step();
    rd_status("st_after41", 32'h0000_0002);
    rx.delete();

    // CPU-side table with console stalled
    i_con_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i_wb_stb  = tbl[i].stb;
      i_wb_we   = tbl[i].we;
      i_wb_addr = tbl[i].addr;
      i_wb_data = tbl[i].data;
      step();
      chk({tbl[i].name, "_ack"}, {31'b0, o_wb_ack},
          {31'b0, tbl[i].exp_ack});
      if (tbl[i].exp_ack) chk(tbl[i].name, o_wb_data, tbl[i].exp_rdata);
    end
    i_wb_stb = 1'b0;
    chk("stalled_no_stb", rx.size(), 0);

    // release: ABC in order
    i_con_stall = 1'b0;
    wait_rx("abc_cnt", 3, 60);
    if (rx.size() == 3) begin
      chk("abc_0", rx[0], 32'h41);
      chk("abc_1", rx[1], 32'h42);
      chk("abc_2", rx[2], 32'h43);
    end
    repeat (4) step();
    rd_status("st_abc_done", 32'h0000_0002);
    rx.delete();

    // overflow: 17 writes into 16 entries
    i_con_stall = 1'b1;
    for (int i = 0; i < 17; i++) wb(1'b1, 1'b0, 32'h60 + i);
    rd_status("st_ovf", 32'h0000_1005);
    wb(1'b1, 1'b1, 32'h4);
    rd_status("st_ovf_clr", 32'h0000_1001);

    // push on the same edge as a pop while full, slow acks
    ack_delay = 10;
    i_con_stall = 1'b0;
    wb(1'b1, 1'b0, 32'h7E);
    rd_status("st_pushpop", 32'h0000_1001);
    wait_rx("full_drain_cnt", 17, 400);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h60 + i);
    exp_q.push_back(32'h7E);
    if (rx.size() == 17)
      for (int i = 0; i < 17; i++) chk($sformatf("drain_%0d", i), rx[i], exp_q[i]);
    repeat (12) step();
    rd_status("st_drained", 32'h0000_0002);
    rx.delete();

    // zero-latency console
    ack_delay = 0;
    wb(1'b1, 1'b0, 32'h31);
    wb(1'b1, 1'b0, 32'h32);
    wait_rx("zl_cnt", 2, 30);
    if (rx.size() == 2) begin
      chk("zl_0", rx[0], 32'h31);
      chk("zl_1", rx[1], 32'h32);
    end
    repeat (3) step();
    rx.delete();

    // reset while waiting for ack with 5 entries queued
    ack_delay = 20;
    i_con_stall = 1'b1;
    for (int i = 0; i < 6; i++) wb(1'b1, 1'b0, 32'h50 + i);
    i_con_stall = 1'b0;
    wait_rx("rst_first_stb", 1, 20);
    chk_stable = 1'b0;
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("rst_mid_stb", {31'b0, o_con_stb}, 32'h0);
    chk("rst_mid_ack", {31'b0, o_wb_ack}, 32'h0);
    rd_status("st_after_rst", 32'h0000_0002);
    repeat (30) step();
    chk("late_ack_no_stb", rx.size(), 1);
    chk("late_ack_stb_low", {31'b0, o_con_stb}, 32'h0);
    rd_status("st_final", 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
